pwm_period_meter: RTL and testbench
===================================

// Module: pwm_period_meter
// PURPOSE
//  Measures a divided/PWM clock, such as a divide-by-N output, in units of clk cycles.
//  It reports the high time, low time and period of each full cycle of sig_in.
//  It sits on the receive side of the PWM/divider blocks, for self-check and ratio monitoring.
//  It also flags a stuck (non-toggling) input.
// PARAMETERS
//  CNT_W       16     width of high_cnt/low_cnt; period_cnt is CNT_W+1
//  SYNC_STAGES 2      synchronizer flops on sig_in (>=2)
//  TIMEOUT     1000   cycles without an edge on s before stuck asserts (1..2^CNT_W-1)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst_n      in   1        asynchronous, active-low reset
//  en         in   1        measurement enable (level)
//  sig_in     in   1        measured signal, asynchronous to clk
//  meas_valid out  1        1-cycle pulse: new result on high_cnt/low_cnt/period_cnt
//  high_cnt   out  CNT_W    cycles s was 1 in last completed period
//  low_cnt    out  CNT_W    cycles s was 0 in last completed period
//  period_cnt out  CNT_W+1  high_cnt+low_cnt, registered together with them
//  stuck      out  1        level: no edge on s for TIMEOUT cycles while en=1
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM=IDLE, sync flops 0.
//  - Signal conditioning:
//    - s = sig_in after SYNC_STAGES flops; s_d = s delayed 1 cycle.
//    - rise = s&~s_d; fall = ~s&s_d.
//  - FSM states are IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW. en=0 in any state forces IDLE next cycle.
//  - IDLE:
//    - Counters are cleared and stuck is forced to 0.
//    - en=1 -> WAIT_RISE.
//  - WAIT_RISE:
//    - The first partial period is discarded.
//    - rise -> MEAS_HIGH with hcnt=1.
//  - MEAS_HIGH:
//    - s=1: hcnt++.
//    - fall: lcnt=1 -> MEAS_LOW.
//  - MEAS_LOW:
//    - s=0: lcnt++.
//    - On rise, the next posedge registers high_cnt=hcnt, low_cnt=lcnt and period_cnt=hcnt+lcnt.
//    - meas_valid=1 for exactly that one cycle.
//    - hcnt=1, stay in MEAS_HIGH (back-to-back measurement, no gap).
//  - Result timing and hold:
//    - Results appear 1 cycle after the rise that closes the period.
//    - Results hold their value until the next meas_valid.
//  - Latency: from sig_in to s is SYNC_STAGES cycles. The H/L counts are exact for an input that is synchronous and stable.
//  - Stuck detection:
//    - idle counter = cycles since the last edge of s, counted only while en=1 and not IDLE.
//    - idle counter == TIMEOUT -> stuck=1, FSM -> WAIT_RISE, no meas_valid.
//    - The first edge after that clears stuck the same cycle the edge is registered.
//    - The next valid result comes only after one full period.
//  - Widths: the counters never wrap, since TIMEOUT < 2^CNT_W aborts first. period_cnt has no overflow.
//  - Minimum period is 2 cycles (1 high, 1 low). Faster input aliases; this is not detected.
//  - en falling mid-period: the partial period is discarded. The last valid results are retained, and no meas_valid is issued.
//  - rst_n asserted mid-operation: everything returns to reset values immediately (async).
// TESTING
//  1. Synchronous divide-by-4 (2 high/2 low), en=1 -> after the first full period:
//     - meas_valid every 4 cycles.
//     - high=2, low=2, period=4.
//  2. Divide-by-3, 1 high/2 low -> high=1, low=2, period=3, with valid every 3 cycles.
//  3. Toggle every cycle (1/1) -> high=1, low=1, period=2, with valid every 2 cycles and no missed pulses.
//  4. TIMEOUT=20, hold sig_in=1 for 30 cycles:
//     - stuck=1 at 20 idle cycles, no valid.
//     - Then a 3/3 square wave -> stuck clears on the first edge, first valid shows 3/3/6.
//  5. en=0 mid-MEAS_LOW, then en=1:
//     - No valid at disable; the previous results are held.
//     - The first new valid comes only after WAIT_RISE plus one full period.
//  6. Assert rst_n during MEAS_HIGH -> all outputs 0 at once; after release, behaviour matches scenario 1 from start.

Source files
------------

// File: rtl/pwm_period_meter.sv
// Measures high time, low time and period of sig_in in clk cycles, and flags
// an input that stops toggling while measurement is enabled.
module pwm_period_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic             meas_valid,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W:0]   period_cnt,
   output logic             stuck
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      MEAS_HIGH = 2'd2,
      MEAS_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_s;
   logic                   s_d_r;
   logic                   rise_s;
   logic                   fall_s;
   logic                   edge_s;
   logic                   active_s;
   logic                   timeout_s;
   logic                   report_s;
   logic                   stuck_nxt_s;
   logic [CNT_W-1:0]       hcnt_r;
   logic [CNT_W-1:0]       hcnt_nxt_s;
   logic [CNT_W-1:0]       lcnt_r;
   logic [CNT_W-1:0]       lcnt_nxt_s;
   logic [CNT_W-1:0]       idle_cnt_r;
   logic [CNT_W-1:0]       idle_nxt_s;

   assign s_s       = sync_r[SYNC_STAGES-1];
   assign rise_s    = s_s & ~s_d_r;
   assign fall_s    = ~s_s & s_d_r;
   assign edge_s    = rise_s | fall_s;
   assign active_s  = en & (state_r != IDLE);
   // An edge in the same cycle the idle counter hits the limit wins over the timeout.
   assign timeout_s = active_s & ~edge_s & (idle_cnt_r == TIMEOUT_C);

   // Synchronizer chain and one-cycle delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         s_d_r  <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
         s_d_r  <= s_s;
      end
   end

   // Idle counter saturates at the timeout and stuck level follows it.
   always_comb begin
      idle_nxt_s  = idle_cnt_r;
      stuck_nxt_s = stuck;
      if (!active_s) begin
         idle_nxt_s  = ZERO_C;
         stuck_nxt_s = 1'b0;
      end else if (edge_s) begin
         idle_nxt_s  = ZERO_C;
         stuck_nxt_s = 1'b0;
      end else if (timeout_s) begin
         idle_nxt_s  = idle_cnt_r;
         stuck_nxt_s = 1'b1;
      end else begin
         idle_nxt_s  = idle_cnt_r + ONE_C;
         stuck_nxt_s = stuck;
      end
   end

   // Next-state and high/low counter update.
   always_comb begin
      state_nxt_s = state_r;
      hcnt_nxt_s  = hcnt_r;
      lcnt_nxt_s  = lcnt_r;
      report_s    = 1'b0;
      if (!en) begin
         state_nxt_s = IDLE;
         hcnt_nxt_s  = ZERO_C;
         lcnt_nxt_s  = ZERO_C;
      end else if (timeout_s) begin
         state_nxt_s = WAIT_RISE;
      end else begin
         case (state_r)
            IDLE: begin
               hcnt_nxt_s  = ZERO_C;
               lcnt_nxt_s  = ZERO_C;
               state_nxt_s = WAIT_RISE;
            end
            WAIT_RISE: begin
               if (rise_s) begin
                  hcnt_nxt_s  = ONE_C;
                  state_nxt_s = MEAS_HIGH;
               end else begin
                  state_nxt_s = WAIT_RISE;
               end
            end
            MEAS_HIGH: begin
               if (fall_s) begin
                  lcnt_nxt_s  = ONE_C;
                  state_nxt_s = MEAS_LOW;
               end else if (s_s) begin
                  hcnt_nxt_s  = hcnt_r + ONE_C;
               end else begin
                  state_nxt_s = MEAS_HIGH;
               end
            end
            MEAS_LOW: begin
               if (rise_s) begin
                  report_s    = 1'b1;
                  hcnt_nxt_s  = ONE_C;
                  state_nxt_s = MEAS_HIGH;
               end else if (!s_s) begin
                  lcnt_nxt_s  = lcnt_r + ONE_C;
               end else begin
                  state_nxt_s = MEAS_LOW;
               end
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // State, counters and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         hcnt_r     <= ZERO_C;
         lcnt_r     <= ZERO_C;
         idle_cnt_r <= ZERO_C;
         stuck      <= 1'b0;
         meas_valid <= 1'b0;
         high_cnt   <= ZERO_C;
         low_cnt    <= ZERO_C;
         period_cnt <= {(CNT_W+1){1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         hcnt_r     <= hcnt_nxt_s;
         lcnt_r     <= lcnt_nxt_s;
         idle_cnt_r <= idle_nxt_s;
         stuck      <= stuck_nxt_s;
         meas_valid <= report_s;
         if (report_s) begin
            high_cnt   <= hcnt_r;
            low_cnt    <= lcnt_r;
            period_cnt <= {1'b0, hcnt_r} + {1'b0, lcnt_r};
         end
      end
   end

endmodule

// File: tb/tb_pwm_period_meter.sv
// Directed bench for pwm_period_meter: square waves driven synchronously to clk,
// stuck timeout, enable drop and mid-run reset.
module tb_pwm_period_meter;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        sig_in;
   logic        meas_valid;
   logic [15:0] high_cnt;
   logic [15:0] low_cnt;
   logic [16:0] period_cnt;
   logic        stuck;

   int errors = 0;
   int checks = 0;
   int first_idx;
   int nvalid;
   int first_clear;
   int nv_hold;

   pwm_period_meter #(
      .CNT_W(16),
      .SYNC_STAGES(2),
      .TIMEOUT(20)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .sig_in(sig_in),
      .meas_valid(meas_valid),
      .high_cnt(high_cnt),
      .low_cnt(low_cnt),
      .period_cnt(period_cnt),
      .stuck(stuck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap(input int n);
      en     = 1'b0;
      sig_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"},  32'(meas_valid), 32'd0);
      chk({tag, "_high"},   32'(high_cnt),   32'd0);
      chk({tag, "_low"},    32'(low_cnt),    32'd0);
      chk({tag, "_period"}, 32'(period_cnt), 32'd0);
      chk({tag, "_stuck"},  32'(stuck),      32'd0);
   endtask

   // Drives hi/lo square wave for n cycles; checks every result and the pulse spacing.
   task automatic run_wave(input string tag, input int hi, input int lo, input int n,
                           input bit start_high, output int first, output int count,
                           output int clear);
      int p;
      int off;
      int prev;
      p     = hi + lo;
      off   = start_high ? 0 : hi;
      first = -1;
      count = 0;
      clear = -1;
      prev  = -1;
      en    = 1'b1;
      for (int i = 0; i < n; i++) begin
         sig_in = (((i + off) % p) < hi);
         tick();
         if (clear < 0 && stuck === 1'b0) clear = i;
         if (meas_valid === 1'b1) begin
            count++;
            if (first < 0) first = i;
            else chk({tag, "_spacing"}, 32'(i - prev), 32'(p));
            prev = i;
            chk({tag, "_high"},   32'(high_cnt),   32'(hi));
            chk({tag, "_low"},    32'(low_cnt),    32'(lo));
            chk({tag, "_period"}, 32'(period_cnt), 32'(p));
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b0;
      sig_in = 1'b0;
      repeat (3) tick();
      chk_outputs_zero("rst_hold");
      rst_n = 1'b1;
      tick();
      chk_outputs_zero("rst_release");

      // divide-by-4, 2 high / 2 low
      idle_gap(4);
      run_wave("s1", 2, 2, 30, 1'b1, first_idx, nvalid, first_clear);
      chk("s1_first", 32'(first_idx), 32'd6);
      chk("s1_count", 32'(nvalid), 32'd6);
      chk("s1_stuck", 32'(first_clear), 32'd0);

      // divide-by-3, 1 high / 2 low
      idle_gap(4);
      run_wave("s2", 1, 2, 30, 1'b1, first_idx, nvalid, first_clear);
      chk("s2_first", 32'(first_idx), 32'd5);
      chk("s2_count", 32'(nvalid), 32'd9);

      // toggle every cycle
      idle_gap(4);
      run_wave("s3", 1, 1, 30, 1'b1, first_idx, nvalid, first_clear);
      chk("s3_first", 32'(first_idx), 32'd4);
      chk("s3_count", 32'(nvalid), 32'd13);

      // input held high: stuck after the idle limit, then a 3/3 wave recovers
      idle_gap(4);
      en      = 1'b1;
      nv_hold = 0;
      for (int i = 0; i < 30; i++) begin
         sig_in = 1'b1;
         tick();
         if (meas_valid === 1'b1) nv_hold++;
         if (i == 22) chk("s4_stuck_before", 32'(stuck), 32'd0);
         if (i == 23) chk("s4_stuck_at", 32'(stuck), 32'd1);
      end
      chk("s4_no_valid", 32'(nv_hold), 32'd0);
      chk("s4_stuck_held", 32'(stuck), 32'd1);
      run_wave("s4", 3, 3, 20, 1'b0, first_idx, nvalid, first_clear);
      chk("s4_clear", 32'(first_clear), 32'd2);
      chk("s4_first", 32'(first_idx), 32'd11);
      chk("s4_count", 32'(nvalid), 32'd2);
      idle_gap(2);
      chk("s4_stuck_idle", 32'(stuck), 32'd0);

      // enable dropped during the low phase: results held, no pulse
      idle_gap(4);
      run_wave("s5a", 2, 5, 20, 1'b1, first_idx, nvalid, first_clear);
      chk("s5a_first", 32'(first_idx), 32'd9);
      chk("s5a_count", 32'(nvalid), 32'd2);
      for (int i = 20; i < 26; i++) begin
         en     = 1'b0;
         sig_in = ((i % 7) < 2);
         tick();
         chk("s5_dis_valid", 32'(meas_valid), 32'd0);
         chk("s5_dis_period", 32'(period_cnt), 32'd7);
      end
      chk("s5_dis_high", 32'(high_cnt), 32'd2);
      chk("s5_dis_low", 32'(low_cnt), 32'd5);
      idle_gap(4);
      chk("s5_gap_period", 32'(period_cnt), 32'd7);
      run_wave("s5b", 3, 1, 20, 1'b1, first_idx, nvalid, first_clear);
      chk("s5b_first", 32'(first_idx), 32'd6);
      chk("s5b_count", 32'(nvalid), 32'd4);

      // asynchronous reset while measuring the high phase
      idle_gap(4);
      run_wave("s6a", 2, 2, 11, 1'b1, first_idx, nvalid, first_clear);
      chk("s6a_count", 32'(nvalid), 32'd2);
      chk("s6a_period", 32'(period_cnt), 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("s6_async");
      #1;
      rst_n  = 1'b1;
      en     = 1'b0;
      sig_in = 1'b0;
      idle_gap(3);
      chk_outputs_zero("s6_after");
      run_wave("s6b", 2, 2, 20, 1'b1, first_idx, nvalid, first_clear);
      chk("s6b_first", 32'(first_idx), 32'd6);
      chk("s6b_count", 32'(nvalid), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
